// File: rtl/conm_test_ctrl_pkg.sv
// Shared definitions for the CoNM test-control device: register offsets and verdict states.
package conm_test_ctrl_pkg;

  localparam logic [4:0] TC_TOHOST = 5'h00;
  localparam logic [4:0] TC_CYC_LO = 5'h04;
  localparam logic [4:0] TC_CYC_HI = 5'h08;
  localparam logic [4:0] TC_LIMIT  = 5'h0C;
  localparam logic [4:0] TC_CHAR   = 5'h10;
  localparam logic [4:0] TC_STATUS = 5'h14;

  typedef enum logic [1:0] {
    TC_RUN  = 2'd0,
    TC_PASS = 2'd1,
    TC_FAIL = 2'd2,
    TC_TOUT = 2'd3
  } tc_state_e;

  // Registers are word-aligned; the two byte-lane bits never select anything.
  function automatic logic [4:0] tc_word_addr(input logic [4:0] byte_addr);
    return {byte_addr[4:2], 2'b00};
  endfunction

endpackage

// File: rtl/conm_test_fifo.sv
// 8-bit synchronous console FIFO; a push into a full FIFO is taken only alongside a pop.
module conm_test_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [7:0]             din,
  output logic [7:0]             dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? 8'h00 : mem_q[rd_ptr_q];
  assign count   = count_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; count_q alone decides which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/conm_test_ctrl.sv
// Bus-mapped test controller: sticky pass/fail/timeout verdict, frozen cycle counter, console byte stream.
module conm_test_ctrl
  import conm_test_ctrl_pkg::*;
#(
  parameter int          FIFO_DEPTH      = 4,
  parameter logic [31:0] TIMEOUT_DEFAULT = 32'd2500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [4:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ack,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        done,
  output logic        pass,
  output logic        timeout,
  output logic [30:0] fail_num
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  tc_state_e   state_q, state_d;
  logic [63:0] cycle_q, cycle_d;
  logic [31:0] limit_q, limit_d;
  logic [31:0] cyc_hi_q, cyc_hi_d;
  logic [30:0] fail_num_q, fail_num_d;
  logic [31:0] rdata_q, rdata_d;
  logic        ack_q, ack_d;

  logic [4:0]    reg_addr;
  logic          addr_unused;
  logic          is_char_wr, accept;
  logic          tohost_pass, tohost_fail;
  logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [3:0]    count4;

  assign reg_addr    = tc_word_addr(addr);
  assign addr_unused = ^addr[1:0];
  assign is_char_wr  = we && (reg_addr == TC_CHAR);
  assign fifo_pop    = tx_valid && tx_ready;
  // A CHAR write into a full FIFO stalls unless a byte leaves on the same edge.
  assign accept      = req && !ack_q && !(is_char_wr && fifo_full && !fifo_pop);
  assign fifo_push   = accept && is_char_wr;
  assign count4      = 4'(fifo_count);

  conm_test_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (wdata[7:0]),
    .dout  (tx_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign tx_valid = !fifo_empty;
  assign done     = (state_q != TC_RUN);
  assign pass     = (state_q == TC_PASS);
  assign timeout  = (state_q == TC_TOUT);
  assign fail_num = fail_num_q;
  assign rdata    = rdata_q;
  assign ack      = ack_q;

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    cycle_d     = cycle_q;
    limit_d     = limit_q;
    cyc_hi_d    = cyc_hi_q;
    fail_num_d  = fail_num_q;
    rdata_d     = '0;
    ack_d       = accept;
    tohost_pass = 1'b0;
    tohost_fail = 1'b0;

    if (state_q == TC_RUN) cycle_d = cycle_q + 64'd1;

    if (accept) begin
      if (we) begin
        if (reg_addr == TC_TOHOST && wdata[0] && state_q == TC_RUN) begin
          tohost_pass = (wdata == 32'd1);
          tohost_fail = (wdata != 32'd1);
        end
        if (reg_addr == TC_LIMIT && state_q == TC_RUN) limit_d = wdata;
      end else begin
        case (reg_addr)
          TC_TOHOST: rdata_d = {fail_num_q, pass};
          TC_CYC_LO: begin
            rdata_d  = cycle_q[31:0];
            cyc_hi_d = cycle_q[63:32];
          end
          TC_CYC_HI: rdata_d = cyc_hi_q;
          TC_LIMIT:  rdata_d = limit_q;
          TC_STATUS: rdata_d = {20'd0, count4, 5'd0, timeout, pass, done};
          default:   rdata_d = '0;
        endcase
      end
    end

    // A firmware verdict on the same edge as the watchdog hit takes priority.
    if (state_q == TC_RUN) begin
      if (tohost_pass) begin
        state_d = TC_PASS;
      end else if (tohost_fail) begin
        state_d    = TC_FAIL;
        fail_num_d = wdata[31:1];
      end else if (limit_q != 32'd0 && cycle_q[31:0] >= limit_q) begin
        state_d = TC_TOUT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= TC_RUN;
      cycle_q    <= '0;
      limit_q    <= TIMEOUT_DEFAULT;
      cyc_hi_q   <= '0;
      fail_num_q <= '0;
      rdata_q    <= '0;
      ack_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cycle_q    <= cycle_d;
      limit_q    <= limit_d;
      cyc_hi_q   <= cyc_hi_d;
      fail_num_q <= fail_num_d;
      rdata_q    <= rdata_d;
      ack_q      <= ack_d;
    end
  end

endmodule
